// File: rtl/object_spawner_pkg.sv
// Shared game constants, FSM encoding and lane helpers for the falling-object spawner.
// The collision checker imports the same screen constants so both agree on geometry.
package object_spawner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    localparam int unsigned X_W    = 8;
    localparam int unsigned Y_W    = 7;
    localparam int unsigned LFSR_W = 16;
    localparam int unsigned CNT8_W = 8;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    // Screen geometry
    localparam int unsigned Y_BOTTOM     = 120;
    localparam int unsigned CAR_ROW      = 70;
    localparam int unsigned POLICE_W     = 20;
    localparam int unsigned COIN_SIZE    = 8;
    localparam int unsigned COIN_STAGGER = 60;

    // Lane table: four lanes, police x = LANE_OFFSET + lane*LANE_PITCH
    localparam int unsigned LANE_PITCH  = 40;
    localparam int unsigned LANE_OFFSET = 10;
    localparam int unsigned COIN_INSET  = 6;

    function automatic logic [X_W-1:0] police_x(input logic [1:0] lane);
        return X_W'(LANE_OFFSET + 32'(lane) * LANE_PITCH);
    endfunction

    function automatic logic [X_W-1:0] coin_x(input logic [1:0] lane);
        return X_W'(LANE_OFFSET + 32'(lane) * LANE_PITCH + COIN_INSET);
    endfunction

    // Coin lane candidate is bumped one lane (mod 4) when it collides with the police lane
    function automatic logic [1:0] pick_coin_lane(input logic [1:0] cand, input logic [1:0] police);
        return (cand == police) ? cand + 2'd1 : cand;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running whenever not in reset.
// Ports: clk, rst (sync, active-high), state (current 16-bit register value).
module lfsr16
    import object_spawner_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state
);

    // Right-shifting form: feedback of bits 0,2,3,5 enters at the MSB
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else begin
            state <= {state[0] ^ state[2] ^ state[3] ^ state[5], state[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/object_spawner.sv
// Police car / coin spawner: frame tick generation, object fall, hit/bottom respawn
// with pseudo-random distinct lanes, dodge counting and start/freeze control.
// Ports: CLOCK_50, Reset (sync, active-high), EnterEn (start pulse), GameOver (freeze level),
//        CoinEn/PoliceEn (hit pulses); x_po/y_po, x_coin/y_coin (object positions),
//        FrameTick (per-frame strobe), Active (running), Dodged (saturating exit count).
module object_spawner
    import object_spawner_pkg::*;
#(
    parameter int unsigned FRAME_DIV = 833333
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              EnterEn,
    input  logic              GameOver,
    input  logic              CoinEn,
    input  logic              PoliceEn,
    output logic [X_W-1:0]    x_po,
    output logic [Y_W-1:0]    y_po,
    output logic [X_W-1:0]    x_coin,
    output logic [Y_W-1:0]    y_coin,
    output logic              FrameTick,
    output logic              Active,
    output logic [CNT8_W-1:0] Dodged
);

    localparam int unsigned     CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    state_t              state, state_n;
    logic [CNT_W-1:0]    frame_cnt, frame_cnt_n;
    logic [LFSR_W-1:0]   lfsr;
    logic [1:0]          police_lane, police_lane_n;
    logic [1:0]          coin_lane, coin_lane_n;
    logic [Y_W-1:0]      y_po_n, y_coin_n;
    logic [X_W-1:0]      x_po_n, x_coin_n;
    logic [CNT8_W-1:0]   dodged_n;
    logic                tick_c;
    logic                init, police_respawn, coin_respawn, dodge_inc, clear_dodged;
    logic [7:0]          y_po_inc, y_coin_inc;
    logic                lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (CLOCK_50),
        .rst   (Reset),
        .state (lfsr)
    );

    assign lfsr_unused = ^lfsr[LFSR_W-1:4];
    assign tick_c      = (frame_cnt == CNT_LAST);

    // Increments are 8 bits wide so y=119 -> 120 is detectable as off-screen
    assign y_po_inc    = {1'b0, y_po} + 8'd1;
    assign y_coin_inc  = {1'b0, y_coin} + 8'd1;

    // State register and all registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state       <= ST_IDLE;
            frame_cnt   <= '0;
            police_lane <= 2'd0;
            coin_lane   <= 2'd0;
            x_po        <= '0;
            y_po        <= '0;
            x_coin      <= '0;
            y_coin      <= '0;
            FrameTick   <= 1'b0;
            Active      <= 1'b0;
            Dodged      <= '0;
        end else begin
            state       <= state_n;
            frame_cnt   <= frame_cnt_n;
            police_lane <= police_lane_n;
            coin_lane   <= coin_lane_n;
            x_po        <= x_po_n;
            y_po        <= y_po_n;
            x_coin      <= x_coin_n;
            y_coin      <= y_coin_n;
            // Registered strobe lines up with the cycle the counter sits at its last value
            FrameTick   <= (frame_cnt_n == CNT_LAST);
            Active      <= (state_n == ST_RUN);
            Dodged      <= dodged_n;
        end
    end

    // Next-state, movement and respawn decisions
    always_comb begin
        state_n        = state;
        frame_cnt_n    = tick_c ? '0 : frame_cnt + CNT_W'(1);
        police_lane_n  = police_lane;
        coin_lane_n    = coin_lane;
        x_po_n         = x_po;
        y_po_n         = y_po;
        x_coin_n       = x_coin;
        y_coin_n       = y_coin;
        dodged_n       = Dodged;
        init           = 1'b0;
        police_respawn = 1'b0;
        coin_respawn   = 1'b0;
        dodge_inc      = 1'b0;
        clear_dodged   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (EnterEn) begin
                    state_n = ST_RUN;
                    init    = 1'b1;
                end
            end
            ST_RUN: begin
                // GameOver outranks hits and movement in the same cycle
                if (GameOver) begin
                    state_n = ST_FREEZE;
                end else begin
                    if (PoliceEn) begin
                        police_respawn = 1'b1;
                    end else if (tick_c) begin
                        if (y_po_inc >= 8'(Y_BOTTOM)) begin
                            police_respawn = 1'b1;
                            dodge_inc      = 1'b1;
                        end else begin
                            y_po_n = Y_W'(y_po_inc);
                        end
                    end
                    if (CoinEn) begin
                        coin_respawn = 1'b1;
                    end else if (tick_c) begin
                        if (y_coin_inc >= 8'(Y_BOTTOM)) begin
                            coin_respawn = 1'b1;
                        end else begin
                            y_coin_n = Y_W'(y_coin_inc);
                        end
                    end
                end
            end
            ST_FREEZE: begin
                if (EnterEn) begin
                    state_n      = ST_RUN;
                    init         = 1'b1;
                    clear_dodged = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Police lane resolves first so the coin can avoid a same-cycle police respawn
        if (init || police_respawn) begin
            police_lane_n = lfsr[1:0];
            y_po_n        = '0;
            x_po_n        = police_x(lfsr[1:0]);
        end
        if (init || coin_respawn) begin
            coin_lane_n = pick_coin_lane(lfsr[3:2], police_lane_n);
            y_coin_n    = init ? Y_W'(COIN_STAGGER) : '0;
            x_coin_n    = coin_x(coin_lane_n);
        end

        if (clear_dodged) begin
            dodged_n = '0;
        end else if (dodge_inc && (Dodged != 8'hFF)) begin
            dodged_n = Dodged + 8'd1;
        end
    end

endmodule

// File: tb/tb_object_spawner.sv
// Directed self-checking bench for object_spawner (FRAME_DIV=4 main instance,
// FRAME_DIV=1 second instance used only to reach Dodged saturation quickly).
module tb_object_spawner;

    logic       CLOCK_50 = 1'b0;
    logic       Reset, EnterEn, GameOver, CoinEn, PoliceEn;
    logic [7:0] x_po, x_coin, Dodged;
    logic [6:0] y_po, y_coin;
    logic       FrameTick, Active;

    logic       Reset2, EnterEn2;
    logic [7:0] x_po2, x_coin2, Dodged2;
    logic [6:0] y_po2, y_coin2;
    logic       FrameTick2, Active2;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] m_lfsr;
    logic [15:0] lf;
    logic [7:0]  x_hold, xc_hold;

    always #5 CLOCK_50 = ~CLOCK_50;

    object_spawner #(.FRAME_DIV(4)) dut (
        .CLOCK_50 (CLOCK_50), .Reset (Reset), .EnterEn (EnterEn), .GameOver (GameOver),
        .CoinEn (CoinEn), .PoliceEn (PoliceEn), .x_po (x_po), .y_po (y_po),
        .x_coin (x_coin), .y_coin (y_coin), .FrameTick (FrameTick), .Active (Active),
        .Dodged (Dodged)
    );

    object_spawner #(.FRAME_DIV(1)) dut_fast (
        .CLOCK_50 (CLOCK_50), .Reset (Reset2), .EnterEn (EnterEn2), .GameOver (1'b0),
        .CoinEn (1'b0), .PoliceEn (1'b0), .x_po (x_po2), .y_po (y_po2),
        .x_coin (x_coin2), .y_coin (y_coin2), .FrameTick (FrameTick2), .Active (Active2),
        .Dodged (Dodged2)
    );

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1
    always @(posedge CLOCK_50) begin
        if (Reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    function automatic logic [7:0] lane_x(input logic [1:0] l);
        return 8'(10 + 40 * int'(l));
    endfunction

    function automatic logic [1:0] exp_coin_lane(input logic [1:0] cand, input logic [1:0] pol);
        return (cand == pol) ? cand + 2'd1 : cand;
    endfunction

    function automatic logic is_lane(input logic [7:0] x);
        return (x == 8'd10) || (x == 8'd50) || (x == 8'd90) || (x == 8'd130);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLOCK_50);
    endtask

    // Leaves us at a negedge where FrameTick is high (bounded wait)
    task automatic wait_tick();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (FrameTick === 1'b1) found = 1'b1;
            else @(negedge CLOCK_50);
        end
        chk("frame_tick_seen", 32'(found), 32'd1);
    endtask

    task automatic tick();
        wait_tick();
        step();
        chk("x_po_legal", 32'(is_lane(x_po)), 32'd1);
        chk("x_coin_legal", 32'(is_lane(x_coin - 8'd6)), 32'd1);
    endtask

    task automatic reset_then_idle();
        Reset = 1'b1;
        repeat (3) step();
        chk("rst_x_po", 32'(x_po), 32'd0);
        chk("rst_y_po", 32'(y_po), 32'd0);
        chk("rst_x_coin", 32'(x_coin), 32'd0);
        chk("rst_y_coin", 32'(y_coin), 32'd0);
        chk("rst_tick", 32'(FrameTick), 32'd0);
        chk("rst_active", 32'(Active), 32'd0);
        chk("rst_dodged", 32'(Dodged), 32'd0);
        Reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("idle_tick_pattern", 32'(FrameTick), 32'((i % 4) == 3));
        end
        chk("idle_y_po", 32'(y_po), 32'd0);
        chk("idle_x_po", 32'(x_po), 32'd0);
        chk("idle_y_coin", 32'(y_coin), 32'd0);
        chk("idle_active", 32'(Active), 32'd0);
    endtask

    // Pulse EnterEn and check the INIT placement against the reference LFSR
    task automatic enter_and_check(input string tag);
        lf      = m_lfsr;
        EnterEn = 1'b1;
        step();
        EnterEn = 1'b0;
        chk({tag, "_active"}, 32'(Active), 32'd1);
        chk({tag, "_y_po"}, 32'(y_po), 32'd0);
        chk({tag, "_y_coin"}, 32'(y_coin), 32'd60);
        chk({tag, "_x_po"}, 32'(x_po), 32'(lane_x(lf[1:0])));
        chk({tag, "_x_coin"}, 32'(x_coin), 32'(lane_x(exp_coin_lane(lf[3:2], lf[1:0])) + 8'd6));
    endtask

    initial begin
        Reset = 1'b1; EnterEn = 1'b0; GameOver = 1'b0; CoinEn = 1'b0; PoliceEn = 1'b0;
        Reset2 = 1'b1; EnterEn2 = 1'b0;

        // Saturation on the fast instance: one exit every 120 cycles
        repeat (3) step();
        Reset2 = 1'b0;
        step();
        EnterEn2 = 1'b1;
        step();
        EnterEn2 = 1'b0;
        chk("sat_start", 32'(Dodged2), 32'd0);
        repeat (30479) step();
        chk("sat_253", 32'(Dodged2), 32'd253);
        step();
        chk("sat_254", 32'(Dodged2), 32'd254);
        repeat (120) step();
        chk("sat_255", 32'(Dodged2), 32'd255);
        repeat (5400) step();
        chk("sat_hold_300", 32'(Dodged2), 32'd255);
        chk("sat_y_po", 32'(y_po2), 32'd0);

        // Reset + idle, then start
        reset_then_idle();
        enter_and_check("init1");

        repeat (10) tick();
        chk("ten_ticks_y_po", 32'(y_po), 32'd10);
        chk("ten_ticks_y_coin", 32'(y_coin), 32'd70);

        // Police to the bottom row, then one more frame exits it
        repeat (109) tick();
        chk("bottom_y_po", 32'(y_po), 32'd119);
        chk("bottom_y_coin", 32'(y_coin), 32'd59);
        wait_tick();
        lf = m_lfsr;
        step();
        chk("exit_y_po", 32'(y_po), 32'd0);
        chk("exit_x_po", 32'(x_po), 32'(lane_x(lf[1:0])));
        chk("exit_dodged", 32'(Dodged), 32'd1);
        chk("exit_y_coin", 32'(y_coin), 32'd60);

        // Hit on the collision row in the same cycle as a frame tick
        repeat (70) tick();
        chk("hit_row_y_coin", 32'(y_coin), 32'd10);
        wait_tick();
        chk("hit_row_y_po", 32'(y_po), 32'd70);
        lf = m_lfsr;
        PoliceEn = 1'b1; CoinEn = 1'b1;
        step();
        PoliceEn = 1'b0; CoinEn = 1'b0;
        chk("hit_y_po", 32'(y_po), 32'd0);
        chk("hit_y_coin", 32'(y_coin), 32'd0);
        chk("hit_dodged", 32'(Dodged), 32'd1);
        chk("hit_x_po", 32'(x_po), 32'(lane_x(lf[1:0])));
        chk("hit_x_coin", 32'(x_coin), 32'(lane_x(exp_coin_lane(lf[3:2], lf[1:0])) + 8'd6));

        // GameOver beats a simultaneous hit; positions freeze
        repeat (40) tick();
        chk("pre_freeze_y_po", 32'(y_po), 32'd40);
        x_hold  = x_po;
        xc_hold = x_coin;
        GameOver = 1'b1; PoliceEn = 1'b1;
        step();
        PoliceEn = 1'b0;
        chk("freeze_active", 32'(Active), 32'd0);
        chk("freeze_y_po", 32'(y_po), 32'd40);
        chk("freeze_y_coin", 32'(y_coin), 32'd40);
        repeat (50) tick();
        chk("frozen_y_po", 32'(y_po), 32'd40);
        chk("frozen_y_coin", 32'(y_coin), 32'd40);
        chk("frozen_x_po", 32'(x_po), 32'(x_hold));
        chk("frozen_x_coin", 32'(x_coin), 32'(xc_hold));
        chk("frozen_active", 32'(Active), 32'd0);
        chk("frozen_dodged", 32'(Dodged), 32'd1);
        GameOver = 1'b0;
        enter_and_check("restart");
        chk("restart_dodged", 32'(Dodged), 32'd0);

        // Reset mid-run, then the same start timing reproduces the same lanes
        repeat (55) tick();
        chk("pre_reset_y_po", 32'(y_po), 32'd55);
        Reset = 1'b1;
        step();
        chk("midrst_y_po", 32'(y_po), 32'd0);
        chk("midrst_x_po", 32'(x_po), 32'd0);
        chk("midrst_y_coin", 32'(y_coin), 32'd0);
        chk("midrst_x_coin", 32'(x_coin), 32'd0);
        chk("midrst_active", 32'(Active), 32'd0);
        chk("midrst_dodged", 32'(Dodged), 32'd0);
        chk("midrst_tick", 32'(FrameTick), 32'd0);
        reset_then_idle();
        enter_and_check("init2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/object_spawner.md
Name: object_spawner

Overview:
Produces and animates the falling police car and coin that the collision checker tests against the player car. It owns object position state, pseudo-random lane choice and the frame-rate movement tick. It consumes the CoinEn/PoliceEn hit pulses from the collision checker and respawns the hit object. Its position outputs drive both the VGA draw path and the collision checker.

Parameters:
FRAME_DIV, 833333, CLOCK_50 cycles per movement frame (60 Hz); benches use 4
Y_BOTTOM, 120, first y value that is off-screen; an object reaching it respawns
COIN_STAGGER, 60, coin start y on game start/restart
LANE_PITCH, 40, x distance between lanes (4 lanes)
LANE_OFFSET, 10, police x of lane 0
COIN_INSET, 6, coin x = police-lane x + COIN_INSET (centres 8-px coin in 20-px lane)

Ports:
CLOCK_50  in  1  system clock
Reset  in  1  synchronous, active-high reset
EnterEn  in  1  start/restart request, one-cycle pulse
GameOver  in  1  level from score block; freezes motion
CoinEn  in  1  coin hit pulse from collision checker
PoliceEn  in  1  police hit pulse from collision checker
x_po  out  8  police left x
y_po  out  7  police top y
x_coin  out  8  coin left x
y_coin  out  7  coin top y
FrameTick  out  1  one-cycle pulse per frame (redraw strobe)
Active  out  1  high in RUN
Dodged  out  8  police cars that exited the bottom without a hit, saturating at 255

Behaviour:
- Reset (synchronous, Reset=1 at posedge) sets: state IDLE; all positions 0; FrameTick 0; Active 0; Dodged 0; frame counter 0; LFSR 16'hACE1.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every non-reset cycle in all states, so the seed depends on player timing.
- Lane encoding: lane L in 0..3 maps to police x = LANE_OFFSET + L*LANE_PITCH, giving 10/50/90/130. Coin x is that value + COIN_INSET.
- Frame counter: runs in all states and counts 0..FRAME_DIV-1. FrameTick=1 in the cycle the counter equals FRAME_DIV-1, then the counter wraps to 0.
- FSM states: IDLE, RUN, FREEZE.
  - IDLE: on EnterEn, go to RUN and do INIT.
  - RUN: on GameOver, go to FREEZE. EnterEn is ignored.
  - FREEZE: positions hold. On EnterEn, go to RUN, do INIT and clear Dodged. GameOver is ignored in IDLE.
- INIT (registered on the transition edge):
  - police: y=0, lane=lfsr[1:0].
  - coin: y=COIN_STAGGER, lane=lfsr[3:2]; if that equals the police lane, use (lfsr[3:2]+1) mod 4.
- RUN, per object, priority high to low:
  1. GameOver: freeze wins. No respawn, no move, and any hit pulse in that cycle is discarded.
  2. Hit pulse (PoliceEn for police, CoinEn for coin): respawn next cycle at y=0 with a new lane. Any FrameTick movement of that object in that cycle is skipped.
  3. FrameTick: y_next = y+1, computed 8 bits wide. If y_next >= Y_BOTTOM, respawn at y=0 with a new lane. A police bottom exit increments Dodged, saturating at 255.
- Step size is exactly 1 px per frame, so every y (including the collision row 70) is visited. Respawn on hit prevents the collision checker counting one collision twice while y stays on the hit row for a whole frame.
- Respawn lane: police uses lfsr[1:0]. Coin uses lfsr[3:2], bumped by +1 mod 4 if it equals the police lane currently on screen (or the police lane chosen in the same cycle when both respawn together).
- CoinEn and PoliceEn in the same cycle: both objects respawn, and the lane-distinct rule still holds.
- Outputs are registered. Position changes are visible the cycle after the causing event.
- Reset mid-RUN or mid-FREEZE returns to IDLE with the reset values on the next edge.

Decomposition:
- Shared include game_defs.vh holds:
  - state encodings;
  - lane x table;
  - screen constants: Y_BOTTOM, car row 70, police width 20, coin size 8.
  The collision checker uses the same constants.
- One sub-module, lfsr16: clock, sync reset, 16-bit state out.

Test Plan:
- Reset held 3 cycles, then released with no EnterEn for 20 cycles -> all positions 0, Active 0, Dodged 0, FrameTick pulses every 4 cycles (FRAME_DIV=4).
- EnterEn in IDLE -> next cycle Active=1, y_po=0, y_coin=60, x_po in {10,50,90,130}, x_coin = (a lane x)+6 in a different lane; after 10 FrameTicks y_po=10, y_coin=70.
- Run until police y=119, then one more FrameTick -> y_po=0, new legal lane, Dodged increments by 1; force 300 exits -> Dodged holds at 255.
- PoliceEn and FrameTick asserted in the same cycle at y_po=70 -> y_po=0 next cycle (not 71), Dodged unchanged. CoinEn in the same cycle -> coin also respawns in a distinct lane.
- GameOver asserted at y_po=40 together with PoliceEn -> state FREEZE, y_po stays 40 for 50 ticks, Active=0. EnterEn -> RUN with y_po=0, y_coin=60, Dodged=0.
- Reset pulsed while in RUN at y_po=55 -> next cycle IDLE, all outputs at their reset values. The LFSR sequence restarts from 16'hACE1 and matches the reset-time sequence cycle for cycle.
